serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: diff = a - b - bin, computed one bit per clock, LSB first, with a single full-subtractor cell.
- Complements the combinational ripple-carry adder datapath; used where area matters more than latency.
- Operands enter through a valid/ready handshake; results leave through a valid/ready handshake and are held until consumed.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff, bout and ovf are valid
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin
- ovf  output  1  two's-complement overflow: borrow into MSB XOR borrow out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0; diff = 0; bout = 0; ovf = 0.
  - Internal shift registers, bit counter and borrow flop are cleared.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at an edge: capture a, b into shift registers and bin into the borrow flop, clear the counter, go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge processes bit i = counter:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into the result register MSB side, so after WIDTH shifts bit 0 sits at position 0.
  - On the edge processing bit WIDTH-1:
    - record the borrow into the MSB for ovf;
    - update bout = br_next and ovf = br_in_msb ^ br_next;
    - go to DONE.
- DONE:
  - out_valid = 1; diff, bout, ovf are stable; in_ready = 0.
  - On out_ready at an edge: go to IDLE.
  - There is no same-cycle accept of a new operand in DONE.
- Latency: accept at edge k; out_valid is high after edge k+WIDTH.
- Minimum initiation interval: WIDTH+2 cycles, assuming out_ready is held high.
- Outputs are registered; no combinational path from in_valid or out_ready to any output.
- diff, bout and ovf hold their last values in IDLE and RUN until the next DONE update.
- Input changes while in RUN or DONE are ignored; only the values captured at the accepting edge matter.
- in_valid while in_ready = 0 is not an error; the source holds it until accepted.
- Reset asserted in any state, including mid-RUN: immediate return to reset values; the partial result is discarded.
- Widths: all arithmetic is unsigned modulo 2^WIDTH; the counter is $clog2(WIDTH) bits wide and does not wrap past WIDTH-1.

Test Plan (WIDTH = 4):
1. a=0000, b=0000, bin=0 accepted at edge 0 -> out_valid rises after edge 4; diff=0000, bout=0, ovf=0; in_ready low from edge 0 until return to IDLE.
2. a=1010, b=0011, bin=1 -> diff=0110, bout=0, ovf=1. Then a=0110, b=1001, bin=1 -> diff=1100, bout=1, ovf=1.
3. a=0000, b=1111, bin=0 -> diff=0001, bout=1, ovf=0. Then a=1000, b=0000, bin=1 -> diff=0111, bout=0, ovf=1.
4. Back-pressure: hold out_ready=0 for 3 cycles in DONE while toggling a/b/in_valid -> diff/bout/ovf unchanged, out_valid stays 1, in_ready stays 0. Raise out_ready -> IDLE next edge, in_ready=1.
5. Reset mid-RUN: accept a=1111, b=0001, then pull rst_n low after edge 2 -> in_ready=1, out_valid=0, diff=0000 immediately. After release, a=0101, b=0010, bin=0 -> diff=0011, bout=0.
6. Exhaustive sweep of all a, b, bin with random out_ready stalls -> every result matches the a-b-bin reference model; no result lost or duplicated; out_valid always rises exactly 4 edges after acceptance.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin using one full-subtractor cell, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]  cnt;
    logic           br;
    logic           d;
    logic           br_next;
    logic           last;

    assign d       = sa[0] ^ sb[0] ^ br;
    assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last    = cnt == CW'(WIDTH - 1);

    // The minuend register doubles as the result register: each consumed
    // LSB frees the MSB slot that receives the new difference bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sa       <= a;
                    sb       <= b;
                    br       <= bin;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    sa <= {d, sa[WIDTH-1:1]};
                    sb <= sb >> 1;
                    br <= br_next;
                    if (last) begin
                        diff      <= {d, sa[WIDTH-1:1]};
                        bout      <= br_next;
                        ovf       <= br ^ br_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of serial_subtractor at WIDTH = 4.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
    int         total = 0;
    int         passed = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference result packed as {ovf, bout, diff}
    function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
        int r;
        int s;
        logic [3:0] lo;
        r  = int'(x) - int'(y) - int'(c);
        s  = (x[3] ? int'(x) - 16 : int'(x)) - (y[3] ? int'(y) - 16 : int'(y)) - int'(c);
        lo = r[3:0];
        return {(s < -8) || (s > 7), r < 0, lo};
    endfunction

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic c, input int stall);
        logic [5:0] e;
        int n;
        e = model(x, y, c);
        a = x;
        b = y;
        bin = c;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        bin = 1'($urandom);
        check("busy_ready", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 4);
        check("diff", diff, e[3:0]);
        check("bout", bout, e[4]);
        check("ovf", ovf, e[5]);
        check("done_ready", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            a = 4'($urandom);
            b = 4'($urandom);
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_ready", in_ready, 0);
            check("stall_result", {ovf, bout, diff}, e);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready", in_ready, 1);
        check("idle_valid", out_valid, 0);
        check("idle_hold", {ovf, bout, diff}, e);
    endtask

    initial begin
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_result", {ovf, bout, diff}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'b0000, 4'b0000, 1'b0, 0);
        run_op(4'b1010, 4'b0011, 1'b1, 0);
        check("t2a_exp", {ovf, bout, diff}, 6'b10_0110);
        run_op(4'b0110, 4'b1001, 1'b1, 0);
        check("t2b_exp", {ovf, bout, diff}, 6'b11_1100);
        run_op(4'b0000, 4'b1111, 1'b0, 0);
        check("t3a_exp", {ovf, bout, diff}, 6'b01_0001);
        run_op(4'b1000, 4'b0000, 1'b1, 0);
        check("t3b_exp", {ovf, bout, diff}, 6'b10_0111);
        run_op(4'b0011, 4'b0101, 1'b0, 3);
        // Reset while the operation is mid-RUN
        a = 4'b1111;
        b = 4'b0001;
        bin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_run_valid", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", in_ready, 1);
        check("mrst_valid", out_valid, 0);
        check("mrst_diff", diff, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'b0101, 4'b0010, 1'b0, 0);
        check("t5_exp", {bout, diff}, 5'b0_0011);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int c = 0; c < 2; c++)
                    run_op(4'(i), 4'(j), 1'(c), int'($urandom_range(0, 2)));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
